// File: rtl/seven_seg_scan_decoder_pkg.sv
// Shared constants and helpers for the seven-segment scan link.
// The segment patterns must stay in step with the transmit-side driver.
package seven_seg_pkg;

    localparam logic [4:0] SEL_D1    = 5'b01000;
    localparam logic [4:0] SEL_D2    = 5'b00001;
    localparam logic [4:0] SEL_BLANK = 5'b00000;

    localparam logic [7:0] SEG_0 = 8'h3F;
    localparam logic [7:0] SEG_1 = 8'h06;
    localparam logic [7:0] SEG_2 = 8'h5B;
    localparam logic [7:0] SEG_3 = 8'h4F;

    typedef enum logic {WAIT, PULSE} frame_state_t;

    typedef struct packed {
        logic       legal;
        logic [1:0] value;
    } seg_code_t;

    // Exact match including dp; anything else is illegal.
    function automatic seg_code_t seg_decode(input logic [7:0] pattern);
        seg_code_t c;
        c.legal = 1'b1;
        c.value = 2'd0;
        case (pattern)
            SEG_0:   c.value = 2'd0;
            SEG_1:   c.value = 2'd1;
            SEG_2:   c.value = 2'd2;
            SEG_3:   c.value = 2'd3;
            default: c.legal = 1'b0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/seven_seg_scan_decoder_digit_filter.sv
// Per-digit glitch filter: decodes the pattern, tracks a candidate value and
// how many consecutive identical samples it has seen, and flags acceptance.
module seg_digit_filter
    import seven_seg_pkg::*;
#(
    parameter int STABLE_CNT = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sample_en_i,
    input  logic [7:0] pattern_i,
    input  logic       flush_i,
    output logic       accept_o,
    output logic [1:0] value_o,
    output logic       illegal_o
);

    localparam logic [3:0] CNT_MAX = 4'(STABLE_CNT);

    logic [1:0] cand_q, cand_d;
    logic [3:0] cnt_q, cnt_d, cnt_smp;
    seg_code_t  code;

    // Acceptance is derived from the sample path only, so the flush (which
    // itself depends on acceptance) never feeds back into accept_o.
    always_comb begin
        code    = seg_decode(pattern_i);
        cand_d  = cand_q;
        cnt_smp = cnt_q;
        if (sample_en_i) begin
            if (!code.legal) begin
                cnt_smp = 4'd0;
            end else if (code.value == cand_q) begin
                cnt_smp = (cnt_q >= CNT_MAX) ? CNT_MAX : cnt_q + 4'd1;
            end else begin
                cand_d  = code.value;
                cnt_smp = 4'd1;
            end
        end
        cnt_d = flush_i ? 4'd0 : cnt_smp;
    end

    assign accept_o  = sample_en_i & code.legal & (cnt_smp == CNT_MAX);
    assign value_o   = cand_d;
    assign illegal_o = sample_en_i & ~code.legal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand_q <= 2'd0;
            cnt_q  <= 4'd0;
        end else begin
            cand_q <= cand_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/seven_seg_scan_decoder.sv
// Receive-side decoder for the two-digit scanned seven-segment bus: filters
// each digit, reports frames, sticky errors and a dead-bus timeout.
module seven_seg_scan_decoder
    import seven_seg_pkg::*;
#(
    parameter int STABLE_CNT = 2,
    parameter int TIMEOUT    = 255
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] seg_sel,
    input  logic [7:0] seg_data,
    input  logic       err_clr,
    output logic [1:0] hp1,
    output logic [1:0] hp2,
    output logic       hp1_valid,
    output logic       hp2_valid,
    output logic       frame_valid,
    output logic       decode_err,
    output logic       sel_err,
    output logic       timeout
);

    localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

    logic [4:0]   sel_q;
    logic [7:0]   data_q;
    logic         is_d1, is_d2, sel_bad;
    logic         acc1, acc2, ill1, ill2, any_acc;
    logic [1:0]   val1, val2;
    logic [15:0]  tcnt_q, tcnt_d;
    logic         timeout_hit;
    logic [1:0]   hp1_q, hp2_q;
    logic         hp1_valid_q, hp2_valid_q, frame_valid_q;
    logic         decode_err_q, sel_err_q, timeout_q;
    logic         seen1_q, seen2_q, seen1_nx, seen2_nx;
    frame_state_t state_q;

    assign is_d1   = (sel_q == SEL_D1);
    assign is_d2   = (sel_q == SEL_D2);
    assign sel_bad = !(is_d1 || is_d2 || (sel_q == SEL_BLANK));

    seg_digit_filter #(.STABLE_CNT(STABLE_CNT)) u_digit1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .sample_en_i (is_d1),
        .pattern_i   (data_q),
        .flush_i     (timeout_hit),
        .accept_o    (acc1),
        .value_o     (val1),
        .illegal_o   (ill1)
    );

    seg_digit_filter #(.STABLE_CNT(STABLE_CNT)) u_digit2 (
        .clk         (clk),
        .rst_n       (rst_n),
        .sample_en_i (is_d2),
        .pattern_i   (data_q),
        .flush_i     (timeout_hit),
        .accept_o    (acc2),
        .value_o     (val2),
        .illegal_o   (ill2)
    );

    assign any_acc     = acc1 | acc2;
    assign timeout_hit = !any_acc && (tcnt_q == TO_LAST);
    assign seen1_nx    = seen1_q | acc1;
    assign seen2_nx    = seen2_q | acc2;

    always_comb begin
        tcnt_d = tcnt_q;
        if (any_acc)
            tcnt_d = 16'd0;
        else if (tcnt_q != 16'hFFFF)
            tcnt_d = tcnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q         <= SEL_BLANK;
            data_q        <= 8'd0;
            tcnt_q        <= 16'd0;
            hp1_q         <= 2'd0;
            hp2_q         <= 2'd0;
            hp1_valid_q   <= 1'b0;
            hp2_valid_q   <= 1'b0;
            frame_valid_q <= 1'b0;
            decode_err_q  <= 1'b0;
            sel_err_q     <= 1'b0;
            timeout_q     <= 1'b0;
            seen1_q       <= 1'b0;
            seen2_q       <= 1'b0;
            state_q       <= WAIT;
        end else begin
            sel_q  <= seg_sel;
            data_q <= seg_data;
            tcnt_q <= tcnt_d;

            // A new error in the clear cycle keeps the flag set.
            decode_err_q <= (ill1 | ill2) | (decode_err_q & ~err_clr);
            sel_err_q    <= sel_bad | (sel_err_q & ~err_clr);

            if (any_acc)
                timeout_q <= 1'b0;
            else if (timeout_hit)
                timeout_q <= 1'b1;

            if (acc1) begin
                hp1_q       <= val1;
                hp1_valid_q <= 1'b1;
            end else if (timeout_hit) begin
                hp1_valid_q <= 1'b0;
            end

            if (acc2) begin
                hp2_q       <= val2;
                hp2_valid_q <= 1'b1;
            end else if (timeout_hit) begin
                hp2_valid_q <= 1'b0;
            end

            case (state_q)
                WAIT: begin
                    if (seen1_nx && seen2_nx) begin
                        frame_valid_q <= 1'b1;
                        seen1_q       <= 1'b0;
                        seen2_q       <= 1'b0;
                        state_q       <= PULSE;
                    end else begin
                        frame_valid_q <= 1'b0;
                        seen1_q       <= seen1_nx;
                        seen2_q       <= seen2_nx;
                    end
                end
                PULSE: begin
                    frame_valid_q <= 1'b0;
                    seen1_q       <= seen1_nx;
                    seen2_q       <= seen2_nx;
                    state_q       <= WAIT;
                end
                default: state_q <= WAIT;
            endcase

            if (timeout_hit) begin
                seen1_q <= 1'b0;
                seen2_q <= 1'b0;
            end
        end
    end

    assign hp1         = hp1_q;
    assign hp2         = hp2_q;
    assign hp1_valid   = hp1_valid_q;
    assign hp2_valid   = hp2_valid_q;
    assign frame_valid = frame_valid_q;
    assign decode_err  = decode_err_q;
    assign sel_err     = sel_err_q;
    assign timeout     = timeout_q;

endmodule
